sdram_burst_scheduler: RTL and testbench
========================================

Name: sdram_burst_scheduler

Overview:
- Shares the single full-page SDRAM burst engine (sdram_fifo_interface) between two clients.
  - Display line-fetch reader: high priority.
  - Frame writer: low priority, with anti-starvation.
- Arbitrates requests and drives the 3-bit command and 15-bit page address.
- Steers the engine's per-word FIFO strobes to the owning client, counts completed bursts and runs a hang watchdog.
- Sits between the client FIFOs and sdram_fifo_interface, in the CLK_OUT domain.

Parameters:
MAX_RD_STREAK, 4, consecutive read grants allowed while wr_req is pending before the writer is forced in (1..15)
TIMEOUT_CYCLES, 4096, maximum cycles from issue to engine idle before err is set (fits a 16-bit counter)

Ports:
CLK_OUT  in  1  system clock, shared with the SDRAM engine
rst_n  in  1  asynchronous, active-low reset
sched_en  in  1  1 = new grants allowed; 0 = finish current burst, then hold
rd_req  in  1  reader wants one 512-word burst
rd_page  in  15  reader page: [14:2] row, [1:0] bank
rd_grant  out  1  1-cycle pulse, read burst issued
rd_done  out  1  1-cycle pulse, read burst complete
rd_push  out  1  read-FIFO push strobe, = if_w_fifo while reader owns the engine
wr_req  in  1  writer wants one 512-word burst
wr_page  in  15  writer page, same format
wr_grant  out  1  1-cycle pulse, write burst issued
wr_done  out  1  1-cycle pulse, write burst complete
wr_pop  out  1  write-FIFO pop strobe, = if_r_fifo while writer owns the engine
cmd  out  3  to engine: 000 idle, 001 read, 010 write
page_addr  out  15  to engine f_addr; held for the whole burst
if_idle  in  1  engine in_idle
if_r_fifo  in  1  engine r_fifo (write burst word strobe)
if_w_fifo  in  1  engine w_fifo (read burst word strobe)
rd_bursts  out  16  completed read bursts, wraps at 65535 -> 0
wr_bursts  out  16  completed write bursts, wraps
err  out  1  sticky watchdog flag
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst_n=0):
  - State S_IDLE; cmd=000, page_addr=0.
  - All grant/done/strobe outputs 0; counters 0; err=0; streak counter 0; owner=none.
- All outputs are registered except rd_push/wr_pop, which are combinational AND of the engine strobe with the registered owner.
- FSM:
  - S_IDLE: arbitration only when sched_en=1 and if_idle=1.
    - Winner choice:
      - Reader wins if rd_req=1, unless streak==MAX_RD_STREAK and wr_req=1.
      - Otherwise the writer wins if wr_req=1.
    - On win:
      - Latch the winner's page into page_addr.
      - Set owner.
      - Drive cmd (001 read / 010 write).
      - Pulse the matching grant for 1 cycle.
      - Go to S_ISSUE.
  - S_ISSUE:
    - Hold cmd and page_addr until if_idle=0 is sampled.
    - On that edge: cmd<=000, go to S_BUSY.
    - cmd must be 000 before the engine can re-enter idle; no double issue is permitted.
  - S_BUSY:
    - Wait for if_idle=1.
    - On that edge: pulse the owner's done, increment its counter, go to S_DONE.
  - S_DONE: one cycle; owner<=none; return to S_IDLE.
    - Minimum gap between bursts: 1 idle cycle.
- Streak counter (4-bit):
  - A read grant with wr_req=1 increments it, saturating at MAX_RD_STREAK.
  - A write grant clears it.
  - A read grant with wr_req=0 clears it.
- Client rule: req/page are sampled only in S_IDLE. A client wanting no further burst drops req before its done pulse. The page must be stable while req=1.
- Simultaneous rd_req and wr_req with streak<MAX: reader wins.
- sched_en falling mid-burst: the burst completes normally; no grant occurs afterwards until sched_en=1.
- Watchdog:
  - A 16-bit counter runs in S_ISSUE/S_BUSY and is cleared in S_IDLE.
  - Reaching TIMEOUT_CYCLES sets err; the FSM keeps waiting and never aborts the engine.
  - err_clr clears err; if err_clr and the set condition occur in the same cycle, set wins.
- Strobes: rd_push=if_w_fifo & owner==rd; wr_pop=if_r_fifo & owner==wr. Strobes arriving while owner=none are dropped.
- Reset mid-burst: the scheduler returns to S_IDLE immediately. The engine shares rst_n, so both restart together.

Test Plan:
- rd_req=1, rd_page=0x0123, engine model idles for 600 cycles -> rd_grant pulse, cmd=001 until if_idle falls, page_addr=0x0123; exactly 512 rd_push; rd_done once; rd_bursts=1.
- rd_req and wr_req held high continuously, MAX_RD_STREAK=4 -> grant order R,R,R,R,W,R,R,R,R,W; wr_bursts=2 after 10 bursts.
- Both requests rise in the same cycle with streak=0 -> reader granted first; cmd is 000 in the cycle after the engine leaves idle; no second issue occurs.
- Engine model never returns idle, TIMEOUT_CYCLES=4096 -> err=1 on cycle 4096 after issue; err_clr pulse while still stuck -> err remains 1 (set wins).
- sched_en dropped mid write burst -> wr_done occurs and wr_bursts increments; pending rd_req is not granted until sched_en=1.
- rst_n asserted in S_BUSY -> cmd=000, owner none, counters 0; if_w_fifo pulses during reset produce no rd_push.

Source files
------------

// File: rtl/sdram_burst_scheduler.sv
// Shares the full-page SDRAM burst engine between a high-priority display reader and a
// frame writer, forcing the writer in after MAX_RD_STREAK reads while it waits.
module sdram_burst_scheduler #(
  parameter int unsigned MAX_RD_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK_OUT,
  input  logic        rst_n,
  input  logic        sched_en,
  input  logic        rd_req,
  input  logic [14:0] rd_page,
  output logic        rd_grant,
  output logic        rd_done,
  output logic        rd_push,
  input  logic        wr_req,
  input  logic [14:0] wr_page,
  output logic        wr_grant,
  output logic        wr_done,
  output logic        wr_pop,
  output logic [2:0]  cmd,
  output logic [14:0] page_addr,
  input  logic        if_idle,
  input  logic        if_r_fifo,
  input  logic        if_w_fifo,
  output logic [15:0] rd_bursts,
  output logic [15:0] wr_bursts,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_BUSY = 2'd2, S_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_RD = 2'd1, OWN_WR = 2'd2} owner_t;

  localparam logic [2:0]  CMD_IDLE   = 3'b000;
  localparam logic [2:0]  CMD_READ   = 3'b001;
  localparam logic [2:0]  CMD_WRITE  = 3'b010;
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_RD_STREAK);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [14:0] page_q, page_d;
  logic        rd_grant_q, rd_grant_d, wr_grant_q, wr_grant_d;
  logic        rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic [15:0] rd_bursts_q, rd_bursts_d, wr_bursts_q, wr_bursts_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [15:0] wdog_inc_s;
  logic        wdog_set_s;

  // Watchdog saturates so the set condition persists for as long as the engine stays stuck
  assign wdog_inc_s = (wdog_q == TIMEOUT_W) ? wdog_q : wdog_q + 16'd1;

  // Next-state, arbitration, watchdog and error logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_d       = cmd_q;
    page_d      = page_q;
    rd_grant_d  = 1'b0;
    wr_grant_d  = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    rd_bursts_d = rd_bursts_q;
    wr_bursts_d = wr_bursts_q;
    streak_d    = streak_q;
    wdog_d      = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (sched_en && if_idle) begin
          if (rd_req && !((streak_q == STREAK_MAX) && wr_req)) begin
            page_d     = rd_page;
            owner_d    = OWN_RD;
            cmd_d      = CMD_READ;
            rd_grant_d = 1'b1;
            state_d    = S_ISSUE;
            if (wr_req) begin
              streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
            end else begin
              streak_d = 4'd0;
            end
          end else if (wr_req) begin
            page_d     = wr_page;
            owner_d    = OWN_WR;
            cmd_d      = CMD_WRITE;
            wr_grant_d = 1'b1;
            state_d    = S_ISSUE;
            streak_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_d = wdog_inc_s;
        // Dropping cmd as soon as the engine leaves idle prevents a second issue
        if (!if_idle) begin
          cmd_d   = CMD_IDLE;
          state_d = S_BUSY;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_BUSY: begin
        wdog_d = wdog_inc_s;
        if (if_idle) begin
          state_d = S_DONE;
          if (owner_q == OWN_RD) begin
            rd_done_d   = 1'b1;
            rd_bursts_d = rd_bursts_q + 16'd1;
          end else if (owner_q == OWN_WR) begin
            wr_done_d   = 1'b1;
            wr_bursts_d = wr_bursts_q + 16'd1;
          end else begin
            rd_done_d = 1'b0;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        cmd_d   = CMD_IDLE;
        state_d = S_IDLE;
      end
    endcase

    wdog_set_s = ((state_q == S_ISSUE) || (state_q == S_BUSY)) && (wdog_d == TIMEOUT_W);
    if (wdog_set_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and registered-output flops
  always_ff @(posedge CLK_OUT or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cmd_q       <= CMD_IDLE;
      page_q      <= 15'd0;
      rd_grant_q  <= 1'b0;
      wr_grant_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_bursts_q <= 16'd0;
      wr_bursts_q <= 16'd0;
      streak_q    <= 4'd0;
      wdog_q      <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_q       <= cmd_d;
      page_q      <= page_d;
      rd_grant_q  <= rd_grant_d;
      wr_grant_q  <= wr_grant_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      rd_bursts_q <= rd_bursts_d;
      wr_bursts_q <= wr_bursts_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
    end
  end

  assign cmd       = cmd_q;
  assign page_addr = page_q;
  assign rd_grant  = rd_grant_q;
  assign wr_grant  = wr_grant_q;
  assign rd_done   = rd_done_q;
  assign wr_done   = wr_done_q;
  assign rd_bursts = rd_bursts_q;
  assign wr_bursts = wr_bursts_q;
  assign err       = err_q;
  assign rd_push   = if_w_fifo & (owner_q == OWN_RD);
  assign wr_pop    = if_r_fifo & (owner_q == OWN_WR);

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Self-checking bench for sdram_burst_scheduler: behavioural engine model, word-strobe monitor
// and a grant-order/counter reference model driven with randomized requests and pages.
module tb_sdram_burst_scheduler;

  localparam int MAX_RD = 4;
  localparam int TMO    = 4096;
  localparam int WORDS  = 512;
  localparam int CLK_P  = 10;

  logic        CLK_OUT, rst_n, sched_en, rd_req, wr_req, err_clr;
  logic [14:0] rd_page, wr_page, page_addr;
  logic        rd_grant, rd_done, rd_push, wr_grant, wr_done, wr_pop, err;
  logic [2:0]  cmd;
  logic        if_idle, if_r_fifo, if_w_fifo;
  logic [15:0] rd_bursts, wr_bursts;

  logic eng_idle, eng_w, eng_r, ext_w, eng_hang;
  int   n_chk, n_err, mon_push, mon_pop, model_streak, exp_rd, exp_wr;

  assign if_idle   = eng_idle;
  assign if_w_fifo = eng_w | ext_w;
  assign if_r_fifo = eng_r;

  sdram_burst_scheduler #(.MAX_RD_STREAK(MAX_RD), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_OUT(CLK_OUT), .rst_n(rst_n), .sched_en(sched_en),
    .rd_req(rd_req), .rd_page(rd_page), .rd_grant(rd_grant), .rd_done(rd_done), .rd_push(rd_push),
    .wr_req(wr_req), .wr_page(wr_page), .wr_grant(wr_grant), .wr_done(wr_done), .wr_pop(wr_pop),
    .cmd(cmd), .page_addr(page_addr), .if_idle(if_idle), .if_r_fifo(if_r_fifo),
    .if_w_fifo(if_w_fifo), .rd_bursts(rd_bursts), .wr_bursts(wr_bursts),
    .err(err), .err_clr(err_clr)
  );

  initial begin
    CLK_OUT = 1'b0;
    forever #(CLK_P / 2) CLK_OUT = ~CLK_OUT;
  end

  initial begin
    #(CLK_P * 60000);
    $display("FAIL sim_budget: run did not finish, errors so far %0d", n_err);
    $fatal(1, "simulation budget exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: reader first unless the writer has waited MAX_RD reads
  function automatic int model_grant(input logic r, input logic w);
    if (r && !(model_streak == MAX_RD && w)) begin
      model_streak = w ? ((model_streak + 1 > MAX_RD) ? MAX_RD : model_streak + 1) : 0;
      return 1;
    end
    if (w) begin
      model_streak = 0;
      return 2;
    end
    return 0;
  endfunction

  // Engine model: accepts a command while idle, leaves idle after 0..2 cycles,
  // moves 512 words with random gaps, then returns idle after a short tail.
  initial begin : engine_model
    logic [2:0] issued;
    int lat, words, tail;
    logic strobe;
    eng_idle = 1'b1; eng_w = 1'b0; eng_r = 1'b0;
    forever begin
      @(negedge CLK_OUT);
      if (rst_n && cmd != 3'b000) begin
        issued = cmd;
        lat = $urandom_range(0, 2);
        for (int k = 0; k < lat && rst_n; k++) @(negedge CLK_OUT);
        eng_idle = 1'b0;
        @(negedge CLK_OUT);
        while (eng_hang && rst_n) @(negedge CLK_OUT);
        words = 0;
        while (words < WORDS && rst_n) begin
          strobe = ($urandom_range(0, 3) != 0);
          eng_w  = strobe && (issued == 3'b001);
          eng_r  = strobe && (issued == 3'b010);
          if (strobe) words++;
          @(negedge CLK_OUT);
        end
        eng_w = 1'b0; eng_r = 1'b0;
        tail = $urandom_range(0, 3);
        for (int k = 0; k < tail && rst_n; k++) @(negedge CLK_OUT);
        eng_idle = 1'b1;
      end
    end
  end

  initial begin : strobe_monitor
    mon_push = 0; mon_pop = 0;
    forever begin
      @(negedge CLK_OUT); #1;
      if (rd_push) mon_push++;
      if (wr_pop) mon_pop++;
    end
  end

  task automatic wait_grant(output int kind);
    kind = 0;
    for (int i = 0; i < 4000 && kind == 0; i++) begin
      @(negedge CLK_OUT);
      if (rd_grant) kind = 1;
      else if (wr_grant) kind = 2;
    end
  endtask

  task automatic wait_done(output int kind);
    kind = 0;
    for (int i = 0; i < 6000 && kind == 0; i++) begin
      @(negedge CLK_OUT);
      if (rd_done) kind = 1;
      else if (wr_done) kind = 2;
    end
  endtask

  task automatic issue_phase(input logic r, input logic w, input logic [14:0] rp,
                             input logic [14:0] wp, input logic keep, output int exp_k,
                             output int pb, output int wb, output time t_g);
    int got_k, n;
    logic [2:0] exp_cmd;
    rd_page = rp; wr_page = wp; rd_req = r; wr_req = w;
    exp_k = model_grant(r, w);
    wait_grant(got_k);
    t_g = $time;
    if (!keep) begin
      rd_req = 1'b0; wr_req = 1'b0;
    end
    exp_cmd = (exp_k == 1) ? 3'b001 : 3'b010;
    check("grant_kind", 32'(got_k), 32'(exp_k));
    check("page_addr", 32'(page_addr), 32'((exp_k == 1) ? rp : wp));
    n = 0;
    #1;
    while (if_idle && n < 8) begin
      check("cmd_hold", 32'(cmd), 32'(exp_cmd));
      @(negedge CLK_OUT); #1;
      n++;
    end
    @(negedge CLK_OUT);
    check("cmd_clear", 32'(cmd), 32'd0);
    pb = mon_push; wb = mon_pop;
  endtask

  task automatic done_phase(input int exp_k, input int pb, input int wb);
    int got_k;
    wait_done(got_k);
    check("done_kind", 32'(got_k), 32'(exp_k));
    if (exp_k == 1) exp_rd++; else exp_wr++;
    check("push_words", 32'(mon_push - pb), 32'((exp_k == 1) ? WORDS : 0));
    check("pop_words", 32'(mon_pop - wb), 32'((exp_k == 2) ? WORDS : 0));
    check("rd_bursts", 32'(rd_bursts), 32'(exp_rd % 65536));
    check("wr_bursts", 32'(wr_bursts), 32'(exp_wr % 65536));
  endtask

  initial begin : main
    int k, pb, wb, n, sel;
    time tg;
    logic [14:0] pr, pw;
    n_chk = 0; n_err = 0; model_streak = 0; exp_rd = 0; exp_wr = 0;
    rst_n = 1'b0; sched_en = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_page = 15'd0; wr_page = 15'd0; err_clr = 1'b0; ext_w = 1'b0; eng_hang = 1'b0;
    repeat (3) @(negedge CLK_OUT);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_page", 32'(page_addr), 32'd0);
    check("rst_grants", 32'({rd_grant, wr_grant, rd_done, wr_done}), 32'd0);
    check("rst_counters", 32'({rd_bursts, wr_bursts}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK_OUT);

    // Single read burst to a fixed page
    issue_phase(1'b1, 1'b0, 15'h0123, 15'h0000, 1'b0, k, pb, wb, tg);
    done_phase(k, pb, wb);

    // Both clients held high: R,R,R,R,W,R,R,R,R,W
    pr = 15'($urandom); pw = 15'($urandom);
    for (int g = 0; g < 10; g++) begin
      issue_phase(1'b1, 1'b1, pr, pw, (g < 9), k, pb, wb, tg);
      done_phase(k, pb, wb);
    end
    check("wr_after_streak", 32'(wr_bursts), 32'd2);

    // Simultaneous rise with a cleared streak: reader first
    issue_phase(1'b1, 1'b1, 15'($urandom), 15'($urandom), 1'b0, k, pb, wb, tg);
    check("both_rise_reader", 32'(k), 32'd1);
    done_phase(k, pb, wb);

    // Randomized request mixes
    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(1, 3);
      issue_phase(sel[0], sel[1], 15'($urandom), 15'($urandom), 1'b0, k, pb, wb, tg);
      done_phase(k, pb, wb);
      repeat ($urandom_range(0, 4)) @(negedge CLK_OUT);
    end

    // sched_en dropped during a write burst
    issue_phase(1'b0, 1'b1, 15'($urandom), 15'($urandom), 1'b0, k, pb, wb, tg);
    repeat (50) @(negedge CLK_OUT);
    sched_en = 1'b0; rd_req = 1'b1; pr = 15'($urandom); rd_page = pr;
    done_phase(k, pb, wb);
    n = 0;
    repeat (40) begin
      @(negedge CLK_OUT);
      if (rd_grant || wr_grant) n++;
    end
    check("hold_no_grant", 32'(n), 32'd0);
    sched_en = 1'b1;
    issue_phase(1'b1, 1'b0, pr, 15'd0, 1'b0, k, pb, wb, tg);
    done_phase(k, pb, wb);

    // Stuck engine: watchdog fires TMO cycles after the grant, set beats clear
    eng_hang = 1'b1;
    issue_phase(1'b1, 1'b0, 15'($urandom), 15'd0, 1'b0, k, pb, wb, tg);
    while ($time < tg + time'((TMO - 1) * CLK_P)) @(negedge CLK_OUT);
    check("err_early", 32'(err), 32'd0);
    @(negedge CLK_OUT);
    check("err_timeout", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge CLK_OUT);
    err_clr = 1'b0;
    check("err_set_wins", 32'(err), 32'd1);
    eng_hang = 1'b0;
    done_phase(k, pb, wb);
    check("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge CLK_OUT);
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // Reset in the middle of a read burst
    issue_phase(1'b1, 1'b0, 15'($urandom), 15'd0, 1'b0, k, pb, wb, tg);
    n = 0;
    while ((mon_push - pb) < 20 && n < 200) begin
      @(negedge CLK_OUT);
      n++;
    end
    rst_n = 1'b0; ext_w = 1'b1;
    #1;
    check("rst_mid_push", 32'(rd_push), 32'd0);
    check("rst_mid_cmd", 32'(cmd), 32'd0);
    check("rst_mid_page", 32'(page_addr), 32'd0);
    check("rst_mid_counters", 32'({rd_bursts, wr_bursts}), 32'd0);
    pb = mon_push;
    repeat (3) @(negedge CLK_OUT);
    check("rst_push_count", 32'(mon_push - pb), 32'd0);
    ext_w = 1'b0; rst_n = 1'b1;
    model_streak = 0; exp_rd = 0; exp_wr = 0;
    repeat (2) @(negedge CLK_OUT);
    issue_phase(1'b1, 1'b1, 15'($urandom), 15'($urandom), 1'b0, k, pb, wb, tg);
    done_phase(k, pb, wb);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
